// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, duration limits and phase one-hot codes for the traffic-light path.
package traffic_pkg;
    typedef enum logic [2:0] {RUN_R, RUN_G, RUN_Y, SET_R, SET_G, SET_Y} state_t;
    localparam int DUR_W     = 7;
    localparam int DUR_DEF_R = 3;
    localparam int DUR_DEF_G = 8;
    localparam int DUR_DEF_Y = 4;
    localparam int DUR_MIN   = 1;
    localparam int DUR_MAX   = 99;
    localparam logic [2:0] PH_R    = 3'b100;
    localparam logic [2:0] PH_G    = 3'b010;
    localparam logic [2:0] PH_Y    = 3'b001;
    localparam logic [2:0] PH_NONE = 3'b000;
endpackage

// File: rtl/dur_adjust_reg.sv
// dur_adjust_reg: one editable phase duration with wrap-around increment/decrement.
module dur_adjust_reg #(
    parameter int TW   = 7,
    parameter int DEF  = 3,
    parameter int TMIN = 1,
    parameter int TMAX = 99
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sel,
    input  logic          inc,
    input  logic          dec,
    output logic [TW-1:0] q
);
    localparam logic [TW-1:0] Q_DEF = TW'(DEF);
    localparam logic [TW-1:0] Q_MIN = TW'(TMIN);
    localparam logic [TW-1:0] Q_MAX = TW'(TMAX);
    // simultaneous inc and dec cancel out
    always_ff @(posedge clk) begin
        if (rst)
            q <= Q_DEF;
        else if (sel && (inc ^ dec))
            q <= inc ? ((q == Q_MAX) ? Q_MIN : q + 1'b1)
                     : ((q == Q_MIN) ? Q_MAX : q - 1'b1);
    end
endmodule

// File: rtl/traffic_phase_controller.sv
// traffic_phase_controller: RUN/SET phase sequencer driving phase selects, counter clear/hold and editable durations.
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int TW    = DUR_W,
    parameter int DEF_R = DUR_DEF_R,
    parameter int DEF_G = DUR_DEF_G,
    parameter int DEF_Y = DUR_DEF_Y,
    parameter int TMIN  = DUR_MIN,
    parameter int TMAX  = DUR_MAX
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mode_btn,
    input  logic          inc_btn,
    input  logic          dec_btn,
    input  logic          r_end,
    input  logic          y_end,
    input  logic          g_end,
    output logic          fsm_r,
    output logic          fsm_g,
    output logic          fsm_y,
    output logic          c_s,
    output logic          set_mode,
    output logic [2:0]    edit_sel,
    output logic [TW-1:0] time_r,
    output logic [TW-1:0] time_g,
    output logic [TW-1:0] time_y
);
    state_t     state, state_nxt;
    logic [2:0] phase, phase_nxt, edit_nxt;
    logic       cs_nxt, inc_eff, dec_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= RUN_R;
            phase    <= PH_R;
            edit_sel <= PH_NONE;
            set_mode <= 1'b0;
            c_s      <= 1'b0;
        end else begin
            state    <= state_nxt;
            phase    <= phase_nxt;
            edit_sel <= edit_nxt;
            set_mode <= edit_nxt != PH_NONE;
            c_s      <= cs_nxt;
        end
    end

    // outputs are decoded from the next state so they register alongside it
    always_comb begin
        state_nxt = state;
        case (state)
            RUN_R:   state_nxt = mode_btn ? SET_R : (r_end ? RUN_G : RUN_R);
            RUN_G:   state_nxt = mode_btn ? SET_R : (g_end ? RUN_Y : RUN_G);
            RUN_Y:   state_nxt = mode_btn ? SET_R : (y_end ? RUN_R : RUN_Y);
            SET_R:   state_nxt = mode_btn ? SET_G : SET_R;
            SET_G:   state_nxt = mode_btn ? SET_Y : SET_G;
            SET_Y:   state_nxt = mode_btn ? RUN_R : SET_Y;
            default: state_nxt = RUN_R;
        endcase
        phase_nxt = (state_nxt == RUN_R) ? PH_R :
                    (state_nxt == RUN_G) ? PH_G :
                    (state_nxt == RUN_Y) ? PH_Y : PH_NONE;
        edit_nxt  = (state_nxt == SET_R) ? PH_R :
                    (state_nxt == SET_G) ? PH_G :
                    (state_nxt == SET_Y) ? PH_Y : PH_NONE;
        cs_nxt    = (state == SET_Y) && mode_btn;
    end

    assign {fsm_r, fsm_g, fsm_y} = phase;
    // a mode press takes priority and drops any edit in the same cycle
    assign inc_eff = inc_btn & ~mode_btn;
    assign dec_eff = dec_btn & ~mode_btn;

    dur_adjust_reg #(.TW(TW), .DEF(DEF_R), .TMIN(TMIN), .TMAX(TMAX)) u_dur_r (
        .clk(clk), .rst(rst), .sel(edit_sel[2]), .inc(inc_eff), .dec(dec_eff), .q(time_r)
    );
    dur_adjust_reg #(.TW(TW), .DEF(DEF_G), .TMIN(TMIN), .TMAX(TMAX)) u_dur_g (
        .clk(clk), .rst(rst), .sel(edit_sel[1]), .inc(inc_eff), .dec(dec_eff), .q(time_g)
    );
    dur_adjust_reg #(.TW(TW), .DEF(DEF_Y), .TMIN(TMIN), .TMAX(TMAX)) u_dur_y (
        .clk(clk), .rst(rst), .sel(edit_sel[0]), .inc(inc_eff), .dec(dec_eff), .q(time_y)
    );
endmodule

// File: tb/tb_traffic_phase_controller.sv
// tb_traffic_phase_controller: scoreboard bench with a phase-counter environment and an abstract sequencer model.
module tb_traffic_phase_controller;
    logic       clk = 1'b0;
    logic       rst = 1'b1, mode_btn = 1'b0, inc_btn = 1'b0, dec_btn = 1'b0;
    logic       r_end = 1'b0, g_end = 1'b0, y_end = 1'b0;
    logic       fsm_r, fsm_g, fsm_y, c_s, set_mode;
    logic [2:0] edit_sel;
    logic [6:0] time_r, time_g, time_y;

    typedef logic [28:0] obs_t;
    obs_t q[$];
    int   total = 0, bad = 0;

    // model: phase index 0=R,1=G,2=Y, a set-mode flag, durations, counter value, expected c_s
    int   ph = 0, cnt = 0;
    bit   in_set = 0, cs = 0;
    int   dur[3] = '{3, 8, 4};

    always #5 clk = ~clk;

    traffic_phase_controller dut (
        .clk(clk), .rst(rst), .mode_btn(mode_btn), .inc_btn(inc_btn), .dec_btn(dec_btn),
        .r_end(r_end), .y_end(y_end), .g_end(g_end),
        .fsm_r(fsm_r), .fsm_g(fsm_g), .fsm_y(fsm_y), .c_s(c_s), .set_mode(set_mode),
        .edit_sel(edit_sel), .time_r(time_r), .time_g(time_g), .time_y(time_y)
    );

    function automatic logic [2:0] onehot(input int p);
        logic [2:0] v;
        v = 3'b100 >> p;
        return v;
    endfunction

    function automatic obs_t expected();
        logic [2:0] act, ed;
        act = in_set ? 3'b000 : onehot(ph);
        ed  = in_set ? onehot(ph) : 3'b000;
        return {act, cs, in_set, ed, 7'(dur[0]), 7'(dur[1]), 7'(dur[2])};
    endfunction

    task automatic step(input bit r, input bit m, input bit i, input bit d, input logic [2:0] sp);
        logic [2:0] act, ends;
        bit         hit;
        int         ncnt;
        bit         ncs;
        @(posedge clk);
        #2;
        act  = in_set ? 3'b000 : onehot(ph);
        ends = (!in_set && cnt == dur[ph]) ? act : 3'b000;
        rst = r; mode_btn = m; inc_btn = i; dec_btn = d;
        {r_end, g_end, y_end} = ends | (sp & ~act);
        if (r) begin
            ph = 0; in_set = 0; cs = 0; cnt = 0;
            dur = '{3, 8, 4};
        end else begin
            hit  = ends != 3'b000;
            ncnt = (cs || in_set || hit) ? 0 : cnt + 1;
            ncs  = in_set && ph == 2 && m;
            if (in_set) begin
                if (m) begin
                    if (ph == 2) begin in_set = 0; ph = 0; end
                    else ph = ph + 1;
                end else if (i != d) begin
                    if (i) dur[ph] = (dur[ph] == 99) ? 1 : dur[ph] + 1;
                    else   dur[ph] = (dur[ph] == 1) ? 99 : dur[ph] - 1;
                end
            end else if (m) begin
                in_set = 1; ph = 0;
            end else if (hit) begin
                ph = (ph + 1) % 3;
            end
            cnt = ncnt;
            cs  = ncs;
        end
        q.push_back(expected());
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 3'b000);
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, want);
        end
    endtask

    always @(posedge clk) begin
        obs_t want, got;
        #1;
        if (q.size() != 0) begin
            want = q.pop_front();
            got  = {fsm_r, fsm_g, fsm_y, c_s, set_mode, edit_sel, time_r, time_g, time_y};
            total++;
            if (got !== want) begin
                bad++;
                $display("FAIL outputs @%0t: got=%h want=%h", $time, got, want);
            end
        end
    end

    initial begin
        step(1, 0, 0, 0, 3'b000);
        step(1, 0, 0, 0, 3'b000);
        idle(25);
        // edit sequence: R+2, G-1, Y untouched
        step(0, 1, 0, 0, 3'b000); idle(1);
        step(0, 0, 1, 0, 3'b000); idle(1);
        step(0, 0, 1, 0, 3'b000);
        step(0, 1, 0, 0, 3'b000);
        step(0, 0, 0, 1, 3'b000);
        step(0, 1, 0, 0, 3'b000);
        step(0, 1, 0, 0, 3'b000);
        idle(2);
        check("time_r_edit", int'(time_r), 5);
        check("time_g_edit", int'(time_g), 7);
        check("time_y_edit", int'(time_y), 4);
        idle(30);
        // wrap around at both limits
        step(0, 1, 0, 0, 3'b000);
        repeat (5) step(0, 0, 0, 1, 3'b000);
        idle(2);
        check("time_r_wrap_dn", int'(time_r), 99);
        step(0, 0, 1, 0, 3'b000); idle(1);
        check("time_r_wrap_up", int'(time_r), 1);
        step(0, 0, 0, 1, 3'b000);
        step(0, 0, 1, 1, 3'b000); idle(1);
        check("time_r_inc_dec", int'(time_r), 99);
        step(0, 1, 0, 0, 3'b000);
        step(0, 1, 0, 0, 3'b000);
        step(0, 1, 0, 0, 3'b000);
        // spurious ends in RUN_R, then r_end in SET_G, then mode+inc in SET_G
        idle(3);
        repeat (4) step(0, 0, 0, 0, 3'b011);
        step(0, 1, 0, 0, 3'b000);
        step(0, 1, 0, 0, 3'b000);
        step(0, 0, 0, 0, 3'b100);
        step(0, 1, 1, 0, 3'b000); idle(1);
        check("time_g_mode_inc", int'(time_g), 7);
        check("edit_sel_set_y", int'(edit_sel), 1);
        step(0, 0, 1, 0, 3'b000);
        step(1, 0, 0, 0, 3'b000); idle(1);
        check("time_r_rst", int'(time_r), 3);
        check("time_g_rst", int'(time_g), 8);
        check("time_y_rst", int'(time_y), 4);
        check("set_mode_rst", int'(set_mode), 0);
        repeat (3000)
            step($urandom_range(0, 599) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'b000);
        idle(1);
        @(posedge clk);
        #3;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
